// File: rtl/acc_frame_arbiter.sv
// Frame-granular arbiter in front of a 4-beat accumulator: one requester owns the input for FRAME_LEN beats.
// Build option ARB_FIXED_PRIO_EN selects lowest-index fixed priority instead of round-robin.
module acc_frame_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned IW        = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_valid,
  output logic [N-1:0]    s_ready,
  input  logic [N*DW-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic [IW-1:0]   m_src,
  output logic            busy,
  output logic            frame_done
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel_idx;
  logic          sel_any;
  logic          accept_c;
  logic [IW-1:0] ptr_nxt;
  int unsigned   best_d;
  int unsigned   d;

  // Pick the set request with the smallest distance from the pointer (or lowest index in fixed mode)
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    best_d  = N;
    d       = 0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      d = i;
`else
      d = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + N - 32'(ptr));
`endif
      if (s_valid[i] && (d < best_d)) begin
        best_d  = d;
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Forward only the granted requester; everything else sees ready low
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if (state == GRANT) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (m_src == IW'(i)) begin
          m_valid    = s_valid[i];
          m_data     = s_data[i*DW +: DW];
          s_ready[i] = m_ready;
        end
      end
    end
  end

  assign accept_c = m_valid & m_ready;
  assign ptr_nxt  = (m_src == IW'(N - 1)) ? '0 : m_src + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      m_src      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            m_src <= sel_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept_c) begin
            if (cnt == CW'(FRAME_LEN - 1)) begin
              cnt        <= '0;
`ifndef ARB_FIXED_PRIO_EN
              ptr        <= ptr_nxt;
`endif
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_frame_arbiter.md
Name: acc_frame_arbiter

Overview:
- Shares one 8-bit valid/ready accumulator input, which sums four beats per result, between N upstream requesters.
- Grants one requester for a whole frame of FRAME_LEN beats, so each accumulated sum comes from a single source. Arbitration between frames is round-robin.
- Sits directly in front of the accumulator and also drives a source tag for the frame in flight.

Parameters:
- N, 4, number of requesters (2..8)
- DW, 8, data width per beat
- FRAME_LEN, 4, accepted beats per granted frame (must match the accumulator group size)
- IW, 2, width of source index; must satisfy 2**IW >= N

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  N  per-requester beat valid
- s_ready  output  N  per-requester beat ready
- s_data  input  N*DW  flattened requester data; requester i occupies bits [i*DW +: DW]
- m_valid  output  1  beat valid to the accumulator
- m_ready  input  1  accumulator ready
- m_data  output  DW  beat data to the accumulator
- m_src  output  IW  index of the granted requester, stable for the whole frame
- busy  output  1  high while a frame is granted
- frame_done  output  1  one-cycle pulse on the clock edge that accepts the last beat of a frame

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port rst.
- Reset values:
  - State is IDLE; the beat counter is 0; the round-robin pointer is 0.
  - Registered outputs: m_src=0, busy=0, frame_done=0.
  - Combinational outputs: m_valid=0, s_ready=0, m_data=0.
- Reset mid-frame: the frame is abandoned immediately with no completion pulse. Downstream is expected to be reset together with this block.
- State IDLE:
  - s_ready=0 and m_valid=0.
  - If any s_valid bit is set, choose the first set bit scanning from index ptr upward, wrapping modulo N.
  - Register the chosen index into m_src and enter GRANT on the next edge.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- State GRANT (g = m_src):
  - m_valid = s_valid[g]; m_data = s_data[g]; s_ready[g] = m_ready; all other s_ready bits are 0. These outputs are purely combinational.
  - A beat is accepted when m_valid && m_ready. Each accepted beat increments the beat counter.
  - On the beat that takes the counter to FRAME_LEN:
    - counter returns to 0 and ptr becomes (g+1) mod N;
    - frame_done pulses for 1 cycle (registered, high in the cycle after the accepting edge);
    - state returns to IDLE.
  - Back-to-back frames therefore have one idle cycle between them.
- Handshake rules:
  - Grant is never revoked mid-frame, even if s_valid[g] deasserts for any number of cycles. Other requesters wait.
  - s_data of a non-granted requester is never forwarded.
  - Upstream must hold s_data stable while s_valid=1 and s_ready=0.
- busy = 1 in GRANT, 0 in IDLE.
- Boundary conditions:
  - A requester that drops s_valid while IDLE is not granted.
  - A request arriving on the same cycle as frame completion is considered in the next IDLE cycle.
  - When a single requester is continuously active, it is re-granted every frame.
  - The counter width is clog2(FRAME_LEN+1). The counter never exceeds FRAME_LEN-1 in GRANT.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: IDLE selection is fixed priority; the lowest set s_valid index wins and ptr is unused (held at 0).
- Undefined: round-robin as described above. All other behaviour is identical in both builds.

Test Plan:
- Reset then a single requester: s_valid=4'b0010 with data 10,20,30,40 and m_ready=1 → m_src=1 from cycle 2; m_data sequence 10,20,30,40; frame_done pulses once; downstream sum = 100.
- All four requesting continuously, m_ready=1 → grant order 0,1,2,3,0; each frame 4 beats with one idle cycle between frames. With ARB_FIXED_PRIO_EN the grant order is 0,0,0,...
- Backpressure: m_ready toggles 1,0,1,0 during a frame → s_ready[g] mirrors m_ready; exactly 4 beats accepted; no data lost or duplicated.
- Granted requester stalls: s_valid[2] low for 5 cycles mid-frame while s_valid[0]=1 → m_src stays 2 and s_ready[0]=0 throughout; frame completes after s_valid[2] returns.
- Reset mid-frame after 2 accepted beats → all outputs return to reset values asynchronously; after release, the next frame starts at ptr=0 with counter 0.
- Values near 8-bit saturation: requester 3 sends 255 four times → 4 beats forwarded unchanged; downstream sum = 1020; frame_done asserted once.
